// File: rtl/cram_frame_loader.sv
// Config-RAM frame loader: powers up the 16 row supplies, clears the 16x4 CRAM and writes 16-nibble frames row by row.
// Optional readback path compiled in with `define CRAM_FRAME_LOADER_RDBK_EN.
module cram_frame_loader #(
  parameter int WL_PULSE   = 3,
  parameter int CLR_CYCLES = 4,
  parameter int PWR_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_b,
`ifdef CRAM_FRAME_LOADER_RDBK_EN
  input  logic [3:0]  bl_in,
  input  logic        start_rd,
  output logic [3:0]  rd_data,
  output logic        rd_valid,
`endif
  input  logic        start_clr,
  input  logic        start_wr,
  input  logic [3:0]  cfg_data,
  input  logic        cfg_valid,
  input  logic        cfg_last,
  output logic        cfg_ready,
  output logic [15:0] wl,
  output logic [15:0] pgate,
  output logic [15:0] cram_reset_b,
  output logic [15:0] vdd_cntl,
  output logic [3:0]  bl_out,
  output logic        bl_oe,
  output logic        prog,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_PWR,
    S_IDLE,
    S_CLEAR,
    S_WAIT_D,
    S_SETUP,
    S_PULSE,
    S_HOLD
`ifdef CRAM_FRAME_LOADER_RDBK_EN
    , S_RDBK
`endif
  } state_t;

  localparam logic [7:0] PWR_LAST = 8'(PWR_CYCLES - 1);
  localparam logic [7:0] CLR_LAST = 8'(CLR_CYCLES - 1);
  localparam logic [7:0] WL_LAST  = 8'(WL_PULSE - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  row_q, row_d;
  logic        last_q, last_d;
  logic [15:0] vdd_q, vdd_d;
  logic [15:0] crst_q, crst_d;
  logic [15:0] wl_q, wl_d;
  logic [3:0]  bl_out_q, bl_out_d;
  logic        bl_oe_q, bl_oe_d;
  logic        ready_q, ready_d;
  logic        prog_q, prog_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef CRAM_FRAME_LOADER_RDBK_EN
  logic [3:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    last_d   = last_q;
    vdd_d    = vdd_q;
    crst_d   = crst_q;
    wl_d     = wl_q;
    bl_out_d = bl_out_q;
    bl_oe_d  = bl_oe_q;
    ready_d  = ready_q;
    prog_d   = prog_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef CRAM_FRAME_LOADER_RDBK_EN
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
`endif
    case (state_q)
      S_PWR: begin
        vdd_d = 16'h0000;
        if (cnt_q == PWR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_IDLE: begin
        if (start_clr) begin
          state_d = S_CLEAR;
          crst_d  = 16'h0000;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          prog_d  = 1'b1;
        end else if (start_wr) begin
          state_d = S_WAIT_D;
          row_d   = 4'd0;
          ready_d = 1'b1;
          err_d   = 1'b0;
          prog_d  = 1'b1;
        end
`ifdef CRAM_FRAME_LOADER_RDBK_EN
        else if (start_rd) begin
          state_d = S_RDBK;
          row_d   = 4'd0;
          wl_d    = 16'h0001;
          bl_oe_d = 1'b0;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          prog_d  = 1'b1;
        end
`endif
      end
      S_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = S_IDLE;
          crst_d  = 16'hFFFF;
          done_d  = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_D: begin
        // bl_out only changes here, while every word-line is low
        if (cfg_valid && ready_q) begin
          state_d  = S_SETUP;
          bl_out_d = cfg_data;
          last_d   = cfg_last;
          ready_d  = 1'b0;
          bl_oe_d  = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        wl_d    = 16'h0001 << row_q;
        cnt_d   = 8'd0;
      end
      S_PULSE: begin
        if (cnt_q == WL_LAST) begin
          state_d = S_HOLD;
          wl_d    = 16'h0000;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        bl_oe_d = 1'b0;
        row_d   = row_q + 4'd1;
        if (row_q == 4'd15) begin
          // a missing last marker still completes the frame, but keeps prog high
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = err_q | ~last_q;
          prog_d  = ~last_q;
        end else if (last_q) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT_D;
          ready_d = 1'b1;
        end
      end
`ifdef CRAM_FRAME_LOADER_RDBK_EN
      S_RDBK: begin
        if (cnt_q == WL_LAST) begin
          rd_data_d  = bl_in;
          rd_valid_d = 1'b1;
          cnt_d      = 8'd0;
          row_d      = row_q + 4'd1;
          if (row_q == 4'd15) begin
            state_d = S_IDLE;
            wl_d    = 16'h0000;
            done_d  = 1'b1;
          end else begin
            wl_d = wl_q << 1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      default: state_d = S_PWR;
    endcase
  end

  // Async reset drops every word-line immediately, even mid-pulse
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= S_PWR;
      cnt_q    <= 8'd0;
      row_q    <= 4'd0;
      last_q   <= 1'b0;
      vdd_q    <= 16'hFFFF;
      crst_q   <= 16'hFFFF;
      wl_q     <= 16'h0000;
      bl_out_q <= 4'd0;
      bl_oe_q  <= 1'b0;
      ready_q  <= 1'b0;
      prog_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef CRAM_FRAME_LOADER_RDBK_EN
      rd_data_q  <= 4'd0;
      rd_valid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      last_q   <= last_d;
      vdd_q    <= vdd_d;
      crst_q   <= crst_d;
      wl_q     <= wl_d;
      bl_out_q <= bl_out_d;
      bl_oe_q  <= bl_oe_d;
      ready_q  <= ready_d;
      prog_q   <= prog_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef CRAM_FRAME_LOADER_RDBK_EN
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`endif
    end
  end

  assign cfg_ready    = ready_q;
  assign wl           = wl_q;
  assign pgate        = wl_q;
  assign cram_reset_b = crst_q;
  assign vdd_cntl     = vdd_q;
  assign bl_out       = bl_out_q;
  assign bl_oe        = bl_oe_q;
  assign prog         = prog_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
`ifdef CRAM_FRAME_LOADER_RDBK_EN
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
`endif

endmodule

// File: tb/tb_cram_frame_loader.sv
// Directed bench for cram_frame_loader: power-up, clear table, frame writes, framing errors, reset mid-pulse.
module tb_cram_frame_loader;

  logic        clk;
  logic        reset_b;
  logic        start_clr;
  logic        start_wr;
  logic [3:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_last;
  logic        cfg_ready;
  logic [15:0] wl;
  logic [15:0] pgate;
  logic [15:0] cram_reset_b;
  logic [15:0] vdd_cntl;
  logic [3:0]  bl_out;
  logic        bl_oe;
  logic        prog;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  cram_frame_loader #(.WL_PULSE(3), .CLR_CYCLES(4), .PWR_CYCLES(8)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .start_clr    (start_clr),
    .start_wr     (start_wr),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_last     (cfg_last),
    .cfg_ready    (cfg_ready),
    .wl           (wl),
    .pgate        (pgate),
    .cram_reset_b (cram_reset_b),
    .vdd_cntl     (vdd_cntl),
    .bl_out       (bl_out),
    .bl_oe        (bl_oe),
    .prog         (prog),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        wr;
    logic [15:0] exp_crst;
    logic        exp_done;
    logic        exp_busy;
    logic        exp_ready;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; last_row=16 means no last marker; rst_row>=0 pulls reset mid-pulse on that row.
  task automatic run_frame(input int bp_row, input int bp_len, input int last_row, input int rst_row);
    int          cyc;
    logic [15:0] exp_wl;
    cyc = 0;
    start_wr = 1'b1;
    step();
    start_wr = 1'b0;
    check("start_err_clr", 32'(err), 32'(0));
    check("start_prog", 32'(prog), 32'(1));
    for (int r = 0; r < 16; r++) begin
      exp_wl = 16'h0001 << r;
      check("wait_ready", 32'(cfg_ready), 32'(1));
      check("wait_wl", 32'(wl), 32'(0));
      if (r == bp_row) begin
        cfg_valid = 1'b0;
        for (int b = 0; b < bp_len; b++) begin
          step();
          cyc++;
          check("bp_ready", 32'(cfg_ready), 32'(1));
          check("bp_wl", 32'(wl), 32'(0));
        end
      end
      cfg_valid = 1'b1;
      cfg_data  = 4'(r);
      cfg_last  = (r == last_row);
      step();
      cyc++;
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      check("setup_ready", 32'(cfg_ready), 32'(0));
      check("setup_bl_oe", 32'(bl_oe), 32'(1));
      check("setup_wl", 32'(wl), 32'(0));
      check("setup_bl_out", 32'(bl_out), 32'(r));
      step();
      cyc++;
      for (int p = 0; p < 3; p++) begin
        check("pulse_wl", 32'(wl), 32'(exp_wl));
        check("pulse_pgate", 32'(pgate), 32'(exp_wl));
        check("pulse_bl_out", 32'(bl_out), 32'(r));
        check("pulse_bl_oe", 32'(bl_oe), 32'(1));
        if (r == rst_row && p == 1) begin
          reset_b = 1'b0;
          #1;
          check("rst_wl", 32'(wl), 32'(0));
          check("rst_pgate", 32'(pgate), 32'(0));
          check("rst_vdd", 32'(vdd_cntl), 32'(16'hFFFF));
          check("rst_crst", 32'(cram_reset_b), 32'(16'hFFFF));
          check("rst_bl_oe", 32'(bl_oe), 32'(0));
          check("rst_bl_out", 32'(bl_out), 32'(0));
          check("rst_ready", 32'(cfg_ready), 32'(0));
          check("rst_prog", 32'(prog), 32'(1));
          check("rst_done", 32'(done), 32'(0));
          check("rst_err", 32'(err), 32'(0));
          return;
        end
        step();
        cyc++;
      end
      check("hold_wl", 32'(wl), 32'(0));
      check("hold_bl_oe", 32'(bl_oe), 32'(1));
      check("hold_bl_out", 32'(bl_out), 32'(r));
      step();
      cyc++;
      check("post_bl_oe", 32'(bl_oe), 32'(0));
      if (r == last_row && r < 15) begin
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_err", 32'(err), 32'(1));
        check("abort_prog", 32'(prog), 32'(1));
        step();
        check("abort_done_later", 32'(done), 32'(0));
        return;
      end
    end
    check("frame_cycles", 32'(cyc), 32'(96 + bp_len));
    check("frame_done", 32'(done), 32'(1));
    check("frame_busy", 32'(busy), 32'(0));
    check("frame_err", 32'(err), 32'(last_row != 15));
    check("frame_prog", 32'(prog), 32'(last_row != 15));
    step();
    check("done_one_cycle", 32'(done), 32'(0));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    reset_b   = 1'b0;
    start_clr = 1'b0;
    start_wr  = 1'b0;
    cfg_data  = 4'd0;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    repeat (3) step();

    check("reset_busy", 32'(busy), 32'(1));
    check("reset_vdd", 32'(vdd_cntl), 32'(16'hFFFF));
    check("reset_crst", 32'(cram_reset_b), 32'(16'hFFFF));
    check("reset_wl", 32'(wl), 32'(0));
    check("reset_pgate", 32'(pgate), 32'(0));
    check("reset_bl_out", 32'(bl_out), 32'(0));
    check("reset_bl_oe", 32'(bl_oe), 32'(0));
    check("reset_ready", 32'(cfg_ready), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_err", 32'(err), 32'(0));
    check("reset_prog", 32'(prog), 32'(1));

    reset_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("pwr_vdd", 32'(vdd_cntl), 32'(16'h0000));
      check("pwr_busy", 32'(busy), 32'(k < 8));
    end
    check("pwr_prog", 32'(prog), 32'(1));

    // clear sequences: clr beats wr, wr ignored while clearing, back-to-back clears
    for (int i = 0; i < 12; i++) begin
      start_clr = tbl[i].clr;
      start_wr  = tbl[i].wr;
      step();
      check("clr_crst", 32'(cram_reset_b), 32'(tbl[i].exp_crst));
      check("clr_done", 32'(done), 32'(tbl[i].exp_done));
      check("clr_busy", 32'(busy), 32'(tbl[i].exp_busy));
      check("clr_ready", 32'(cfg_ready), 32'(tbl[i].exp_ready));
    end
    start_clr = 1'b0;
    start_wr  = 1'b0;

    run_frame(-1, 0, 15, -1);
    run_frame(7, 5, 15, -1);
    run_frame(-1, 0, 3, -1);
    run_frame(-1, 0, 16, -1);
    run_frame(-1, 0, 15, 9);

    repeat (2) step();
    check("rst_hold_vdd", 32'(vdd_cntl), 32'(16'hFFFF));
    reset_b = 1'b1;
    repeat (8) step();
    check("repwr_busy", 32'(busy), 32'(0));
    check("repwr_vdd", 32'(vdd_cntl), 32'(16'h0000));
    check("repwr_prog", 32'(prog), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
